// File: rtl/dsdmnist_requant_pipe.sv
// -----------------------------------------------------------------------------
// dsdmnist_requant_pipe
//
// Pipelined requantizer for the MNIST accelerator post-calculation path.
// A signed accumulator value is multiplied by a per-layer fixed-point
// coefficient taken from a small writable table. The product is then rounded
// (optional), passed through ReLU (optional) and saturated to an OUT_W-bit
// activation. A valid/ready handshake allows one word per cycle.
//
// Pipeline:
//   S1  register the input word and read the coefficient table
//   S2  full-width signed product acc * coeff (no truncation)
//   S3  round / shift / ReLU / clamp into the output register
// All three stages advance together on en = ~o_VALID | i_READY.
// A word captured at one clock edge is presented on o_VALID after the
// second edge that follows it.
//
// Ports:
//   i_CLK, i_RST          clock, synchronous active-high reset
//   i_COEFF_WE/WADDR/WDATA coefficient table write port (visible next cycle)
//   i_VALID, o_READY      input handshake
//   i_ACCVAL              signed accumulator value
//   i_COEFF_SEL           coefficient table index for this word
//   i_RELU, i_ROUND       per-word ReLU enable, round-half-up enable
//   i_TAG                 sideband tag, returned unchanged with the result
//   o_VALID, i_READY      output handshake
//   o_RESULT, o_TAG       quantized result and its tag
//   o_SAT                 result was clipped at a bound
//   i_SAT_CLR, o_SAT_CNT  saturated-handoff counter (sticky at 16'hFFFF)
//
// Parameter constraints: COEFF_FRAC >= 1, NUM_COEFF >= 2.
// -----------------------------------------------------------------------------
module dsdmnist_requant_pipe #(
    parameter int ACC_W      = 25,
    parameter int COEFF_W    = 33,
    parameter int COEFF_FRAC = 32,
    parameter int OUT_W      = 8,
    parameter int NUM_COEFF  = 4,
    parameter int TAG_W      = 8,
    parameter logic [COEFF_W-1:0] COEFF0_INIT = 33'h0_00A3_E3B6,
    parameter logic [COEFF_W-1:0] COEFF1_INIT = 33'h0_0230_FB0F
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic                          i_COEFF_WE,
    input  logic [$clog2(NUM_COEFF)-1:0]  i_COEFF_WADDR,
    input  logic [COEFF_W-1:0]            i_COEFF_WDATA,
    input  logic                          i_VALID,
    output logic                          o_READY,
    input  logic [ACC_W-1:0]              i_ACCVAL,
    input  logic [$clog2(NUM_COEFF)-1:0]  i_COEFF_SEL,
    input  logic                          i_RELU,
    input  logic                          i_ROUND,
    input  logic [TAG_W-1:0]              i_TAG,
    output logic                          o_VALID,
    input  logic                          i_READY,
    output logic [OUT_W-1:0]              o_RESULT,
    output logic [TAG_W-1:0]              o_TAG,
    output logic                          o_SAT,
    input  logic                          i_SAT_CLR,
    output logic [15:0]                   o_SAT_CNT
);

    localparam int AW = $clog2(NUM_COEFF);
    // Full product width, plus one guard bit so the rounding bias can never
    // overflow the signed range.
    localparam int PW = ACC_W + COEFF_W;
    localparam int EW = PW + 1;

    localparam logic signed [EW-1:0] RND_HALF = EW'(1) <<< (COEFF_FRAC - 1);
    localparam logic signed [EW-1:0] UMAX_EXT = EW'((1 << OUT_W) - 1);
    localparam logic signed [EW-1:0] SMAX_EXT = EW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EW-1:0] SMIN_EXT = EW'(-(1 << (OUT_W - 1)));

    // -------------------------------------------------------------------------
    // Global stage enable: every stage moves unless the output is held.
    // -------------------------------------------------------------------------
    logic valid3_q;
    logic en;

    assign en      = ~valid3_q | i_READY;
    assign o_READY = en;

    // -------------------------------------------------------------------------
    // Coefficient table
    // -------------------------------------------------------------------------
    logic signed [COEFF_W-1:0] coeff_q [NUM_COEFF];
    logic [NUM_COEFF-1:0]      wr_hit;

    function automatic logic [COEFF_W-1:0] coeff_reset_val(input int idx);
        if (idx == 0) begin
            return COEFF0_INIT;
        end else if (idx == 1) begin
            return COEFF1_INIT;
        end else begin
            return '0;
        end
    endfunction

    // One decode line per entry. An address at or beyond NUM_COEFF matches no
    // entry, so such a write is dropped without extra logic.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEFF; gi++) begin : g_wr_hit
            assign wr_hit[gi] = i_COEFF_WE & (i_COEFF_WADDR == AW'(gi));
        end
    endgenerate

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                coeff_q[i] <= coeff_reset_val(i);
            end
        end else begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                if (wr_hit[i]) begin
                    coeff_q[i] <= i_COEFF_WDATA;
                end
            end
        end
    end

    // Table read for S1. The table register is sampled before any same-cycle
    // write lands, so a word accepted with a write sees the old value.
    // Out-of-range selects fall through to zero.
    logic signed [COEFF_W-1:0] coeff_rd;

    always_comb begin
        coeff_rd = '0;
        for (int i = 0; i < NUM_COEFF; i++) begin
            if (i_COEFF_SEL == AW'(i)) begin
                coeff_rd = coeff_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // S1: capture word and coefficient
    // -------------------------------------------------------------------------
    logic                      valid1_q;
    logic signed [ACC_W-1:0]   acc1_q;
    logic signed [COEFF_W-1:0] coeff1_q;
    logic                      relu1_q;
    logic                      round1_q;
    logic [TAG_W-1:0]          tag1_q;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            valid1_q <= 1'b0;
            acc1_q   <= '0;
            coeff1_q <= '0;
            relu1_q  <= 1'b0;
            round1_q <= 1'b0;
            tag1_q   <= '0;
        end else if (en) begin
            valid1_q <= i_VALID;
            acc1_q   <= i_ACCVAL;
            coeff1_q <= coeff_rd;
            relu1_q  <= i_RELU;
            round1_q <= i_ROUND;
            tag1_q   <= i_TAG;
        end
    end

    // -------------------------------------------------------------------------
    // S2: full signed product
    // -------------------------------------------------------------------------
    logic                 valid2_q;
    logic signed [PW-1:0] prod2_d;
    logic signed [PW-1:0] prod2_q;
    logic                 relu2_q;
    logic                 round2_q;
    logic [TAG_W-1:0]     tag2_q;

    // Both operands are sign-extended to the product width before multiplying.
    assign prod2_d = PW'(acc1_q) * PW'(coeff1_q);

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            valid2_q <= 1'b0;
            prod2_q  <= '0;
            relu2_q  <= 1'b0;
            round2_q <= 1'b0;
            tag2_q   <= '0;
        end else if (en) begin
            valid2_q <= valid1_q;
            prod2_q  <= prod2_d;
            relu2_q  <= relu1_q;
            round2_q <= round1_q;
            tag2_q   <= tag1_q;
        end
    end

    // -------------------------------------------------------------------------
    // S3: round, arithmetic shift, ReLU / clamp
    // -------------------------------------------------------------------------
    logic signed [EW-1:0] biased;
    logic signed [EW-1:0] shifted;
    logic [OUT_W-1:0]     result3_d;
    logic                 sat3_d;

    always_comb begin
        biased    = EW'(prod2_q) + (round2_q ? RND_HALF : EW'(0));
        // Arithmetic shift gives floor for negative values.
        shifted   = biased >>> COEFF_FRAC;
        result3_d = shifted[OUT_W-1:0];
        sat3_d    = 1'b0;
        if (relu2_q) begin
            // Negative values are clamped to 0 but not flagged as saturated.
            if (shifted[EW-1]) begin
                result3_d = '0;
            end else if (shifted > UMAX_EXT) begin
                result3_d = UMAX_EXT[OUT_W-1:0];
                sat3_d    = 1'b1;
            end
        end else begin
            if (shifted > SMAX_EXT) begin
                result3_d = SMAX_EXT[OUT_W-1:0];
                sat3_d    = 1'b1;
            end else if (shifted < SMIN_EXT) begin
                result3_d = SMIN_EXT[OUT_W-1:0];
                sat3_d    = 1'b1;
            end
        end
    end

    logic [OUT_W-1:0] result3_q;
    logic [TAG_W-1:0] tag3_q;
    logic             sat3_q;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            valid3_q  <= 1'b0;
            result3_q <= '0;
            tag3_q    <= '0;
            sat3_q    <= 1'b0;
        end else if (en) begin
            valid3_q  <= valid2_q;
            result3_q <= result3_d;
            tag3_q    <= tag2_q;
            // A bubble never carries a saturation flag.
            sat3_q    <= valid2_q & sat3_d;
        end
    end

    assign o_VALID  = valid3_q;
    assign o_RESULT = result3_q;
    assign o_TAG    = tag3_q;
    assign o_SAT    = sat3_q;

    // -------------------------------------------------------------------------
    // Saturation counter: counts saturated results at handoff, sticks at max,
    // and a clear takes priority over a same-cycle increment.
    // -------------------------------------------------------------------------
    logic [15:0] sat_cnt_q;
    logic        sat_handoff;

    assign sat_handoff = valid3_q & i_READY & sat3_q;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            sat_cnt_q <= '0;
        end else if (i_SAT_CLR) begin
            sat_cnt_q <= '0;
        end else if (sat_handoff && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign o_SAT_CNT = sat_cnt_q;

endmodule
